board_stream_reader: RTL and testbench

- Read-side counterpart to the board store, which game_logic writes one square at a time through addr/piece/enable.
- Takes an atomic snapshot of the flattened 256-bit board on request, then streams it out one square per valid/ready beat, in ascending address order.
- Keeps per-colour piece counts while scanning.
- Feeds debug/serial or display consumers that must see a consistent board while game_logic keeps updating the live one.

---
 rtl/chess_pkg.sv | 47 ++++
 rtl/board_stream_reader.sv | 158 +++++++++++++++
 tb/tb_board_stream_reader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// ---------------------------------------------------------------------------
// chess_pkg
//
// Shared definitions for the board datapath: square encoding, board width,
// colour and piece codes, the reader FSM state type and a helper that
// classifies a square as empty.
//
// A square is SQ_W = 4 bits wide: {color, piece[2:0]}. The board is the
// 64 squares packed LSB-first into BOARD_W = 256 bits, so square i lives in
// board[4*i+3 : 4*i].
// ---------------------------------------------------------------------------
package chess_pkg;

  localparam int SQ_W    = 4;
  localparam int BOARD_W = 256;

  // Piece kinds as stored in the low three bits of a square.
  typedef enum logic [2:0] {
    PIECE_NONE   = 3'd0,
    PIECE_PAWN   = 3'd1,
    PIECE_KNIGHT = 3'd2,
    PIECE_BISHOP = 3'd3,
    PIECE_ROOK   = 3'd4,
    PIECE_QUEEN  = 3'd5,
    PIECE_KING   = 3'd6
  } piece_t;

  // Colour as stored in the top bit of a square.
  typedef enum logic {
    COLOR_WHITE = 1'b0,
    COLOR_BLACK = 1'b1
  } color_t;

  // States of the board stream reader.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_SEND = 2'd1,
    RD_DONE = 2'd2
  } reader_state_t;

  // A square is empty when its piece field is PIECE_NONE, whatever the
  // colour bit says; both {0,000} and {1,000} count as empty.
  function automatic logic is_empty(input logic [SQ_W-1:0] sq);
    return (sq[2:0] == PIECE_NONE);
  endfunction

endpackage

// File: rtl/board_stream_reader.sv
// ---------------------------------------------------------------------------
// board_stream_reader
//
// Read-side companion of the board store. On a start request it takes an
// atomic snapshot of the flattened board and then streams it out one square
// per valid/ready beat in ascending address order. Optionally, empty squares
// are suppressed (they still take one cycle each, with out_valid low). While
// scanning it counts the non-empty squares of each colour; the counts are
// valid from the done pulse onward and hold until the next accepted start.
//
// Because the stream comes from the snapshot, game_logic may keep updating
// the live board while a consumer walks a consistent copy.
//
// Ports
//   clk          system clock (game logic domain)
//   Reset_n      asynchronous active-low reset
//   board_in     live flattened board, square i = board_in[4i+3:4i]
//   start        request snapshot + stream, only honoured in IDLE
//   skip_empty   suppress empty squares for this stream, latched at start
//   busy         high whenever the reader is not idle
//   out_valid    a beat is presented
//   out_ready    consumer accepts the presented beat
//   out_addr     square address of the presented beat
//   out_piece    square content of the presented beat
//   done         one-cycle pulse after the last square has been scanned
//   white_count  non-empty squares with colour 0
//   black_count  non-empty squares with colour 1
// ---------------------------------------------------------------------------
module board_stream_reader
  import chess_pkg::*;
#(
  parameter int N_SQUARES = 64,
  parameter int SQ_W      = 4
) (
  input  logic                      clk,
  input  logic                      Reset_n,
  input  logic [N_SQUARES*SQ_W-1:0] board_in,
  input  logic                      start,
  input  logic                      skip_empty,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_addr,
  output logic [SQ_W-1:0]           out_piece,
  output logic                      done,
  output logic [6:0]                white_count,
  output logic [6:0]                black_count
);

  localparam logic [5:0] LAST_IDX = 6'(N_SQUARES - 1);

  reader_state_t               state_q;
  reader_state_t               state_d;
  logic [5:0]                  idx_q;
  logic [N_SQUARES*SQ_W-1:0]   snapshot_q;
  logic                        skip_q;
  logic [6:0]                  white_q;
  logic [6:0]                  black_q;

  logic [SQ_W-1:0]             cur;
  logic                        in_send;
  logic                        cur_empty;
  logic                        emit;
  logic                        advance;

  // The square under the scan pointer comes straight out of the snapshot
  // register, so the beat outputs depend only on state, never on inputs.
  assign cur       = snapshot_q[idx_q*SQ_W +: SQ_W];
  assign in_send   = (state_q == RD_SEND);
  assign cur_empty = is_empty(cur);

  // A suppressed square is not presented; it is stepped over in one cycle.
  // Presented squares advance only when the consumer takes them.
  assign emit    = in_send && !(skip_q && cur_empty);
  assign advance = in_send && (!emit || out_ready);

  // Next-state logic: start is only looked at in IDLE, so a start pulse
  // during a scan is simply dropped. The scan leaves SEND from the last
  // address, so idx never wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: begin
        if (start) begin
          state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        if (advance && (idx_q == LAST_IDX)) begin
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        state_d = RD_IDLE;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // State register plus the datapath registers. The snapshot, skip mode,
  // pointer and counts are all initialised together when a start is
  // accepted. Counts bump on every advance over a non-empty square,
  // whether or not that square was presented.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= RD_IDLE;
      idx_q      <= '0;
      snapshot_q <= '0;
      skip_q     <= 1'b0;
      white_q    <= '0;
      black_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        RD_IDLE: begin
          if (start) begin
            snapshot_q <= board_in;
            skip_q     <= skip_empty;
            idx_q      <= '0;
            white_q    <= '0;
            black_q    <= '0;
          end
        end
        RD_SEND: begin
          if (advance) begin
            if (!cur_empty) begin
              if (cur[SQ_W-1] == COLOR_BLACK) begin
                black_q <= black_q + 7'd1;
              end else begin
                white_q <= white_q + 7'd1;
              end
            end
            if (idx_q != LAST_IDX) begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. Address and content are forced to zero outside SEND so
  // the beat bus is quiet whenever nothing is being presented.
  always_comb begin
    busy        = (state_q != RD_IDLE);
    done        = (state_q == RD_DONE);
    out_valid   = emit;
    out_addr    = in_send ? idx_q : 6'd0;
    out_piece   = in_send ? cur : '0;
    white_count = white_q;
    black_count = black_q;
  end

endmodule

// File: tb/tb_board_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_board_stream_reader
//
// Scoreboard bench for board_stream_reader. The stimulus side pushes the
// expected beats of each stream into a queue before starting it; a monitor
// process forked off the main block pops and compares whenever a beat is
// accepted, and checks the counts on every done pulse.
// ---------------------------------------------------------------------------
module tb_board_stream_reader;

  typedef struct packed {
    logic [5:0] addr;
    logic [3:0] piece;
  } beat_t;

  logic         clk;
  logic         Reset_n;
  logic [255:0] board_in;
  logic         start;
  logic         skip_empty;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_addr;
  logic [3:0]   out_piece;
  logic         done;
  logic [6:0]   white_count;
  logic [6:0]   black_count;

  beat_t        exp_q[$];
  beat_t        mon_e;
  logic [3:0]   model_sq[64];
  logic [2:0]   back_row[8];
  int           n_checks;
  int           n_fail;
  int           cyc;
  int           start_cyc;
  int           done_cyc;
  int           done_seen;
  int           beats;
  int           beat_cyc[64];
  int           seen_before;
  bit           found;

  board_stream_reader dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .board_in    (board_in),
    .start       (start),
    .skip_empty  (skip_empty),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_piece   (out_piece),
    .done        (done),
    .white_count (white_count),
    .black_count (black_count)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic loadBoard();
    for (int i = 0; i < 64; i++) begin
      board_in[4*i +: 4] = model_sq[i];
    end
  endtask

  // Queue the expected beats and pulse start; returns #1 after the edge
  // that samples start (edge 0).
  task automatic applyStimulus(input bit skip_v);
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      if (!(skip_v && (model_sq[i][2:0] == 3'b000))) begin
        b.addr  = 6'(i);
        b.piece = model_sq[i];
        exp_q.push_back(b);
      end
    end
    beats = 0;
    @(posedge clk);
    #1;
    start      = 1'b1;
    skip_empty = skip_v;
    @(posedge clk);
    start_cyc = cyc;
    #1;
    start      = 1'b0;
    skip_empty = 1'b0;
  endtask

  task automatic waitDone(input string name, input int exp_cycle, input int exp_beats);
    int  seen0;
    bit  got;
    seen0 = done_seen;
    got   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (done_seen != seen0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no done, expected done by cycle %0d", name, exp_cycle);
    end else begin
      checkOutput({name, "_done_cycle"}, done_cyc - start_cyc, exp_cycle);
      checkOutput({name, "_beats"}, beats, exp_beats);
      checkOutput({name, "_queue_left"}, exp_q.size(), 0);
      #1;
      checkOutput({name, "_busy_after"}, busy, 1'b0);
      repeat (3) @(posedge clk);
      checkOutput({name, "_done_once"}, done_seen, seen0 + 1);
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    start      = 1'b0;
    skip_empty = 1'b0;
    out_ready  = 1'b1;
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    start_cyc  = 0;
    done_cyc   = 0;
    done_seen  = 0;
    beats      = 0;

    // Initial chess position: black back row on 0..7, black pawns 8..15,
    // white pawns 48..55, white back row on 56..63.
    back_row = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    for (int i = 0; i < 64; i++) model_sq[i] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      model_sq[i]      = {1'b1, back_row[i]};
      model_sq[8 + i]  = 4'b1001;
      model_sq[48 + i] = 4'b0001;
      model_sq[56 + i] = {1'b0, back_row[i]};
    end
    loadBoard();

    // Monitor: pops the scoreboard on each accepted beat, checks counts on done.
    fork
      begin
        forever begin
          @(negedge clk);
          cyc++;
          if (Reset_n) begin
            if (out_valid && out_ready) begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_beat: got addr %0d piece %0h, expected no beat", out_addr, out_piece);
              end else begin
                mon_e = exp_q.pop_front();
                checkOutput("beat_addr", out_addr, mon_e.addr);
                checkOutput("beat_piece", out_piece, mon_e.piece);
              end
              beat_cyc[out_addr] = cyc;
              beats++;
            end
            if (done) begin
              done_seen++;
              done_cyc = cyc;
              checkOutput("done_white_count", white_count, 7'd16);
              checkOutput("done_black_count", black_count, 7'd16);
              checkOutput("done_valid_low", out_valid, 1'b0);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_valid", out_valid, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_addr", out_addr, 6'd0);
    checkOutput("reset_piece", out_piece, 4'd0);
    checkOutput("reset_white", white_count, 7'd0);
    checkOutput("reset_black", black_count, 7'd0);
    Reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] full stream, no skip");
    applyStimulus(1'b0);
    checkOutput("noskip_busy_cycle1", busy, 1'b1);
    waitDone("noskip", 65, 64);
    checkOutput("noskip_first_beat_cycle", beat_cyc[0] - start_cyc, 1);
    checkOutput("noskip_last_beat_cycle", beat_cyc[63] - start_cyc, 64);

    $display("[TB] skip empty squares");
    applyStimulus(1'b1);
    waitDone("skip", 65, 32);
    checkOutput("skip_gap_15_to_48", beat_cyc[48] - beat_cyc[15], 33);

    $display("[TB] backpressure on addr 3");
    applyStimulus(1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && (out_addr == 6'd3)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL bp_find_addr3: got no addr 3 beat, expected one within 100 cycles");
    end else begin
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checkOutput("bp_valid_held", out_valid, 1'b1);
        checkOutput("bp_addr_held", out_addr, 6'd3);
        checkOutput("bp_piece_held", out_piece, 4'b1101);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    waitDone("backpressure", 70, 64);
    checkOutput("bp_resume_addr4", beat_cyc[4] - beat_cyc[3], 1);

    $display("[TB] snapshot isolation");
    applyStimulus(1'b0);
    board_in[3:0]     = 4'b0000;
    board_in[163:160] = 4'b0001;
    waitDone("isolation", 65, 64);
    loadBoard();

    $display("[TB] start while busy is ignored");
    applyStimulus(1'b0);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignored_start", 65, 64);
    repeat (80) @(posedge clk);
    checkOutput("ignored_start_no_second_stream", beats, 64);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && (out_addr == 6'd20)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL rst_find_addr20: got no addr 20 beat, expected one within 100 cycles");
    end
    seen_before = done_seen;
    Reset_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_valid", out_valid, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_addr", out_addr, 6'd0);
    checkOutput("midrst_piece", out_piece, 4'd0);
    checkOutput("midrst_white", white_count, 7'd0);
    checkOutput("midrst_black", black_count, 7'd0);
    repeat (3) @(posedge clk);
    #1;
    Reset_n = 1'b1;
    repeat (80) @(posedge clk);
    checkOutput("midrst_no_done", done_seen, seen_before);
    checkOutput("midrst_idle", busy, 1'b0);

    $display("[TB] restart after reset");
    applyStimulus(1'b0);
    waitDone("restart", 65, 64);
    checkOutput("restart_first_beat_cycle", beat_cyc[0] - start_cyc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
